alu_sequencer: RTL and testbench

Hardwired control sequencer for the datapath's fetch cycle and register-register ALU instructions. It owns the T0–T5 control-step sequence: it asserts the PC/MAR/MDR/IR/Y/Z enables, decodes the register fields of IR into one-hot register in/out strobes, and drives the ALU OP code. It sits directly upstream of the datapath and connects to its enable, select and OP inputs. IR is fed back from the datapath's IR register.

---
 rtl/alu_seq_if.sv | 39 +++
 rtl/alu_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Control bundle between the ALU sequencer and the datapath.
// The sequencer drives the enables, strobes and OP. It receives Run and the IR feedback.
interface alu_seq_if #(
    parameter int NREGS = 16
);
    logic             run_i;
    logic [31:0]      ir_i;
    logic             pc_out_o;
    logic             mar_in_o;
    logic             inc_pc_o;
    logic             pc_in_o;
    logic             read_o;
    logic             mdr_in_o;
    logic             mdr_out_o;
    logic             ir_in_o;
    logic             y_in_o;
    logic             z_low_in_o;
    logic             z_high_in_o;
    logic             z_low_out_o;
    logic [NREGS-1:0] r_in_o;
    logic [NREGS-1:0] r_out_o;
    logic [4:0]       op_o;
    logic             halted_o;
    logic [2:0]       step_o;

    modport master (
        input  run_i, ir_i,
        output pc_out_o, mar_in_o, inc_pc_o, pc_in_o, read_o, mdr_in_o,
               mdr_out_o, ir_in_o, y_in_o, z_low_in_o, z_high_in_o,
               z_low_out_o, r_in_o, r_out_o, op_o, halted_o, step_o
    );

    modport slave (
        output run_i, ir_i,
        input  pc_out_o, mar_in_o, inc_pc_o, pc_in_o, read_o, mdr_in_o,
               mdr_out_o, ir_in_o, y_in_o, z_low_in_o, z_high_in_o,
               z_low_out_o, r_in_o, r_out_o, op_o, halted_o, step_o
    );
endinterface

// File: rtl/alu_sequencer.sv
// Hardwired T0-T5 control sequencer for the fetch cycle and reg-reg ALU ops.
// Fixed enables are registered from the next state. The IR-dependent strobes,
// Yin and OP are decoded from the state register and the IR held in the datapath.
module alu_sequencer #(
    parameter int NREGS = 16
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        HALT = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic pc_out_q, mar_in_q, inc_pc_q, pc_in_q, read_q, mdr_in_q;
    logic mdr_out_q, ir_in_q, z_low_in_q, z_high_in_q, z_low_out_q, halted_q;

    logic [4:0]       opcode;
    logic [3:0]       ra, rb, rc;
    logic [4:0]       op_dec;
    logic             op_valid;
    logic [NREGS-1:0] r_in, r_out;
    logic             unused_ir;

    assign opcode    = bus.ir_i[31:27];
    assign ra        = bus.ir_i[26:23];
    assign rb        = bus.ir_i[22:19];
    assign rc        = bus.ir_i[18:15];
    assign unused_ir = ^bus.ir_i[14:0];

    // Opcode to ALU OP code. Anything not listed is unsupported and halts the machine.
    always_comb begin
        op_dec   = 5'b00000;
        op_valid = 1'b1;
        case (opcode)
            5'b00011: op_dec = 5'b00011; // add
            5'b00100: op_dec = 5'b00100; // sub
            5'b00101: op_dec = 5'b00101; // and
            5'b00110: op_dec = 5'b00110; // or
            5'b00111: op_dec = 5'b01000; // shr
            5'b01001: op_dec = 5'b01010; // shl
            5'b01010: op_dec = 5'b01011; // ror
            5'b01011: op_dec = 5'b01100; // rol
            default:  op_valid = 1'b0;
        endcase
    end

    // Next-state logic. Run is looked at only in IDLE and T5.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.run_i ? T0 : IDLE;
            T0:      state_d = T1;
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = op_valid ? T4 : HALT;
            T4:      state_d = T5;
            T5:      state_d = bus.run_i ? T0 : IDLE;
            default: state_d = HALT; // HALT is left only through reset
        endcase
    end

    // State register and registered fixed enables. Clear drops everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_out_q    <= 1'b0;
            mar_in_q    <= 1'b0;
            inc_pc_q    <= 1'b0;
            pc_in_q     <= 1'b0;
            read_q      <= 1'b0;
            mdr_in_q    <= 1'b0;
            mdr_out_q   <= 1'b0;
            ir_in_q     <= 1'b0;
            z_low_in_q  <= 1'b0;
            z_high_in_q <= 1'b0;
            z_low_out_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_out_q    <= (state_d == T0);
            mar_in_q    <= (state_d == T0);
            inc_pc_q    <= (state_d == T0);
            pc_in_q     <= (state_d == T1);
            read_q      <= (state_d == T1);
            mdr_in_q    <= (state_d == T1);
            mdr_out_q   <= (state_d == T2);
            ir_in_q     <= (state_d == T2);
            z_low_in_q  <= (state_d == T0) || (state_d == T4);
            z_high_in_q <= (state_d == T0) || (state_d == T4);
            z_low_out_q <= (state_d == T1) || (state_d == T5);
            halted_q    <= (state_d == HALT);
        end
    end

    // One-hot register strobes: Rb is read in T3, Rc in T4 and Ra is written in T5.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_strobe
            assign r_out[gi] = ((state_q == T3) && op_valid && (rb == 4'(gi)))
                             || ((state_q == T4) && (rc == 4'(gi)));
            assign r_in[gi]  = (state_q == T5) && (ra == 4'(gi));
        end
    endgenerate

    assign bus.pc_out_o    = pc_out_q;
    assign bus.mar_in_o    = mar_in_q;
    assign bus.inc_pc_o    = inc_pc_q;
    assign bus.pc_in_o     = pc_in_q;
    assign bus.read_o      = read_q;
    assign bus.mdr_in_o    = mdr_in_q;
    assign bus.mdr_out_o   = mdr_out_q;
    assign bus.ir_in_o     = ir_in_q;
    assign bus.y_in_o      = (state_q == T3) && op_valid;
    assign bus.z_low_in_o  = z_low_in_q;
    assign bus.z_high_in_o = z_high_in_q;
    assign bus.z_low_out_o = z_low_out_q;
    assign bus.r_in_o      = r_in;
    assign bus.r_out_o     = r_out;
    assign bus.op_o        = (state_q == T4) ? op_dec : 5'b00000;
    assign bus.halted_o    = halted_q;
    assign bus.step_o      = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer. Per-cycle expected output snapshots are
// queued when an instruction is issued and popped at each falling edge.
module tb_alu_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_seq_if #(.NREGS(16)) bus ();

    alu_sequencer #(.NREGS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot layout: {step[3], halted, 12 enables, rin[16], rout[16], op[5]}
    logic [52:0] snap;
    assign snap = {bus.step_o, bus.halted_o,
                   bus.pc_out_o, bus.mar_in_o, bus.inc_pc_o, bus.pc_in_o,
                   bus.read_o, bus.mdr_in_o, bus.mdr_out_o, bus.ir_in_o,
                   bus.y_in_o, bus.z_low_in_o, bus.z_high_in_o, bus.z_low_out_o,
                   bus.r_in_o, bus.r_out_o, bus.op_o};

    logic [52:0] exp_q[$];

    // Reference decode taken from the opcode table: {valid, op}
    function automatic logic [5:0] ref_decode(input logic [4:0] opc);
        case (opc)
            5'b00011: return {1'b1, 5'b00011};
            5'b00100: return {1'b1, 5'b00100};
            5'b00101: return {1'b1, 5'b00101};
            5'b00110: return {1'b1, 5'b00110};
            5'b00111: return {1'b1, 5'b01000};
            5'b01001: return {1'b1, 5'b01010};
            5'b01010: return {1'b1, 5'b01011};
            5'b01011: return {1'b1, 5'b01100};
            default:  return 6'b0;
        endcase
    endfunction

    // Expected snapshot for a given step code and instruction
    function automatic logic [52:0] model(input logic [2:0] st, input logic [31:0] ins);
        logic [5:0]  dec;
        logic        halted;
        logic [11:0] en;   // pc_out mar_in inc_pc pc_in read mdr_in mdr_out ir_in y_in zlin zhin zlout
        logic [15:0] rin, rout;
        logic [4:0]  op;
        dec    = ref_decode(ins[31:27]);
        halted = 1'b0;
        en     = 12'b0;
        rin    = 16'h0;
        rout   = 16'h0;
        op     = 5'b0;
        case (st)
            3'd1: en = 12'b1110_0000_0110;
            3'd2: en = 12'b0001_1100_0001;
            3'd3: en = 12'b0000_0011_0000;
            3'd4: if (dec[5]) begin
                      en   = 12'b0000_0000_1000;
                      rout = 16'h1 << ins[22:19];
                  end
            3'd5: begin
                      en   = 12'b0000_0000_0110;
                      rout = 16'h1 << ins[18:15];
                      op   = dec[4:0];
                  end
            3'd6: begin
                      en  = 12'b0000_0000_0001;
                      rin = 16'h1 << ins[26:23];
                  end
            3'd7: halted = 1'b1;
            default: ;
        endcase
        return {st, halted, en, rin, rout, op};
    endfunction

    // Issues one instruction starting at a falling edge in IDLE or T5 and checks every cycle.
    task automatic do_instr(input string name, input logic [31:0] instr,
                            input bit drop_run, input bit run_after);
        logic [2:0]  seq[$];
        logic [52:0] want;
        if (ref_decode(instr[31:27]) != 6'b0) seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        else                                  seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        bus.run_i = 1'b1;
        bus.ir_i  = $urandom;   // IR is not valid before T3
        foreach (seq[k]) exp_q.push_back(model(seq[k], instr));
        foreach (seq[k]) begin
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (snap !== want) begin
                errors++;
                $display("FAIL %s step%0d: got step=%0d snap=%h, expected step=%0d snap=%h",
                         name, seq[k], snap[52:50], snap, want[52:50], want);
            end
            if (seq[k] == 3'd3) begin
                bus.ir_i = instr;
                if (drop_run) bus.run_i = 1'b0;
            end
            if (seq[k] == 3'd6) bus.run_i = run_after;
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
        return {opc, a, b, c, 15'h0};
    endfunction

    task automatic test_reset();
        logic [52:0] want;
        rst = 1'b1;
        bus.run_i = 1'b0;
        bus.ir_i  = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (snap !== 53'h0) begin
            errors++;
            $display("FAIL reset_initial: got snap=%h, expected 0", snap);
        end
        rst = 1'b0;
        bus.run_i = 1'b1;
        bus.ir_i  = 32'h5B320000;
        for (int s = 1; s <= 5; s++) exp_q.push_back(model(3'(s), bus.ir_i));
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (snap !== want) begin
                errors++;
                $display("FAIL reset_run step%0d: got snap=%h, expected snap=%h", s, snap, want);
            end
        end
        rst = 1'b1;    // mid-T4, away from any clock edge
        #1;
        checks++;
        if (snap !== 53'h0) begin
            errors++;
            $display("FAIL reset_async_T4: got step=%0d snap=%h, expected 0", snap[52:50], snap);
        end
        rst = 1'b0;
        exp_q.push_back(model(3'd1, bus.ir_i));
        @(negedge clk);
        want = exp_q.pop_front();
        checks++;
        if (snap !== want) begin
            errors++;
            $display("FAIL reset_restart: got step=%0d, expected step=%0d (snap %h vs %h)",
                     snap[52:50], want[52:50], snap, want);
        end
        bus.run_i = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic idle_checks(input string name, input int n, input bit toggle_run,
                               input logic [2:0] st);
        logic [52:0] want;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model(st, bus.ir_i));
            if (toggle_run) bus.run_i = ~bus.run_i;
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (snap !== want) begin
                errors++;
                $display("FAIL %s cyc%0d: got step=%0d snap=%h, expected step=%0d snap=%h",
                         name, i, snap[52:50], snap, want[52:50], want);
            end
        end
    endtask

    task automatic test_rol();
        do_instr("rol", 32'h5B320000, 1'b0, 1'b0);
        idle_checks("rol_idle", 2, 1'b0, 3'd0);
    endtask

    task automatic test_back_to_back();
        do_instr("b2b_sub", mk(5'b00100, 4'd3, 4'd7, 4'd9), 1'b0, 1'b1);
        do_instr("b2b_add_hex", 32'h18908000, 1'b0, 1'b1);
        do_instr("b2b_add_r1", mk(5'b00011, 4'd1, 4'd1, 4'd1), 1'b0, 1'b0);
        idle_checks("b2b_idle", 1, 1'b0, 3'd0);
    endtask

    task automatic test_run_drop();
        do_instr("run_drop", mk(5'b00101, 4'd15, 4'd0, 4'd14), 1'b1, 1'b0);
        idle_checks("run_drop_idle", 3, 1'b0, 3'd0);
    endtask

    task automatic test_decode_sweep();
        logic [4:0] opcs [8] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                 5'b00111, 5'b01001, 5'b01010, 5'b01011};
        for (int i = 0; i < 8; i++)
            do_instr($sformatf("sweep_op%0d", i),
                     mk(opcs[i], 4'($urandom), 4'($urandom), 4'($urandom)),
                     1'b0, i < 7);
        idle_checks("sweep_idle", 1, 1'b0, 3'd0);
    endtask

    task automatic test_unsupported();
        do_instr("unsup", 32'hF8000000, 1'b0, 1'b1);
        idle_checks("halt_sticky", 6, 1'b1, 3'd7);
        rst = 1'b1;
        #1;
        checks++;
        if (snap !== 53'h0) begin
            errors++;
            $display("FAIL halt_clear: got snap=%h, expected 0", snap);
        end
        bus.run_i = 1'b0;
        rst = 1'b0;
        idle_checks("after_halt_idle", 2, 1'b0, 3'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.run_i = 1'b0;
        bus.ir_i  = 32'h0;
        test_reset();
        test_rol();
        test_back_to_back();
        test_run_drop();
        test_decode_sweep();
        test_unsupported();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
